// File: rtl/fa_chk_pkg.sv
// Shared types and helpers for the full-adder response checker.
//   vec_t        : applied input vector {a,b,c}
//   state_t      : checker FSM state (IDLE = no previous vector, RUN = prev valid)
//   NUM_VEC      : number of distinct input vectors
//   NUM_TRANS    : number of ordered prev->cur transitions
//   OFFDIAG_MASK : transition map mask with the self-transition bits cleared
//   fa_expected  : golden {carry,sum} for a vector
package fa_chk_pkg;

  typedef logic [2:0] vec_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NUM_VEC   = 8;
  localparam int NUM_TRANS = 64;

  // Bit prev*8+cur; diagonal bits (prev == cur) are 0, 9, 18, ... 63.
  localparam logic [NUM_TRANS-1:0] OFFDIAG_MASK = ~64'h8040_2010_0804_0201;

  function automatic logic [1:0] fa_expected(input vec_t v);
    logic sum;
    logic carry;
    sum   = v[2] ^ v[1] ^ v[0];
    carry = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    return {carry, sum};
  endfunction

endpackage

// File: rtl/fa_ref_model.sv
// Combinational golden full adder.
//   a, b, c : adder inputs
//   exp_y0  : expected sum
//   exp_y1  : expected carry
module fa_ref_model
  import fa_chk_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic exp_y0,
  output logic exp_y1
);

  assign {exp_y1, exp_y0} = fa_expected({a, b, c});

endmodule

// File: rtl/fa_vector_checker.sv
// Response checker for a 3-input full adder. Each valid cycle it compares
// the applied vector's response with a golden model, counts vectors and
// mismatches, captures the first failing vector and builds input and
// prev->cur transition coverage maps.
//   clk, rst          : clock, synchronous active-high reset
//   valid_i           : a/b/c/y0/y1 carry a vector to check this cycle
//   a, b, c           : applied inputs
//   y0, y1            : DUT sum / carry response
//   flush_i           : break the transition chain (FSM back to IDLE)
//   clear_i           : synchronous clear of all statistics
//   err_o             : sticky mismatch flag
//   err_cnt_o         : saturating mismatch count
//   vec_cnt_o         : saturating checked-vector count
//   first_err_vec_o   : {a,b,c,y1,y0} of the first mismatch
//   tt_seen_o/done_o  : per-vector coverage and its completion
//   cov_map_o/done_o  : transition coverage and off-diagonal completion
module fa_vector_checker
  import fa_chk_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 a,
  input  logic                 b,
  input  logic                 c,
  input  logic                 y0,
  input  logic                 y1,
  input  logic                 flush_i,
  input  logic                 clear_i,
  output logic                 err_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [CNT_W-1:0]     vec_cnt_o,
  output logic [4:0]           first_err_vec_o,
  output logic [NUM_VEC-1:0]   tt_seen_o,
  output logic                 tt_done_o,
  output logic [NUM_TRANS-1:0] cov_map_o,
  output logic                 cov_done_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic exp_y0;
  logic exp_y1;

  fa_ref_model u_ref (
    .a      (a),
    .b      (b),
    .c      (c),
    .exp_y0 (exp_y0),
    .exp_y1 (exp_y1)
  );

  state_t               state_reg,     state_next;
  vec_t                 prev_reg,      prev_next;
  logic                 err_reg,       err_next;
  logic [CNT_W-1:0]     err_cnt_reg,   err_cnt_next;
  logic [CNT_W-1:0]     vec_cnt_reg,   vec_cnt_next;
  logic [4:0]           first_err_reg, first_err_next;
  logic [NUM_VEC-1:0]   tt_seen_reg,   tt_seen_next;
  logic                 tt_done_reg,   tt_done_next;
  logic [NUM_TRANS-1:0] cov_map_reg,   cov_map_next;
  logic                 cov_done_reg,  cov_done_next;

  vec_t cur;
  logic mismatch;

  assign cur      = {a, b, c};
  assign mismatch = ({y1, y0} != {exp_y1, exp_y0});

  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    err_next       = err_reg;
    err_cnt_next   = err_cnt_reg;
    vec_cnt_next   = vec_cnt_reg;
    first_err_next = first_err_reg;
    tt_seen_next   = tt_seen_reg;
    cov_map_next   = cov_map_reg;

    if (valid_i) begin
      if (vec_cnt_reg != CNT_MAX)
        vec_cnt_next = vec_cnt_reg + CNT_W'(1);
      if (mismatch) begin
        if (err_cnt_reg != CNT_MAX)
          err_cnt_next = err_cnt_reg + CNT_W'(1);
        // Capture only the first failure since reset/clear.
        if (!err_reg) begin
          err_next       = 1'b1;
          first_err_next = {cur, y1, y0};
        end
      end
      tt_seen_next[cur] = 1'b1;
      // A flushed vector still counts but never forms or starts a chain.
      if (!flush_i) begin
        if (state_reg == RUN)
          cov_map_next[{prev_reg, cur}] = 1'b1;
        prev_next  = cur;
        state_next = RUN;
      end
    end

    if (flush_i)
      state_next = IDLE;

    // Reductions of the next values so the done flags rise together with
    // the bit that completes them.
    tt_done_next  = &tt_seen_next;
    cov_done_next = &(cov_map_next | ~OFFDIAG_MASK);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_reg     <= IDLE;
      prev_reg      <= '0;
      err_reg       <= 1'b0;
      err_cnt_reg   <= '0;
      vec_cnt_reg   <= '0;
      first_err_reg <= '0;
      tt_seen_reg   <= '0;
      tt_done_reg   <= 1'b0;
      cov_map_reg   <= '0;
      cov_done_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      err_reg       <= err_next;
      err_cnt_reg   <= err_cnt_next;
      vec_cnt_reg   <= vec_cnt_next;
      first_err_reg <= first_err_next;
      tt_seen_reg   <= tt_seen_next;
      tt_done_reg   <= tt_done_next;
      cov_map_reg   <= cov_map_next;
      cov_done_reg  <= cov_done_next;
    end
  end

  assign err_o           = err_reg;
  assign err_cnt_o       = err_cnt_reg;
  assign vec_cnt_o       = vec_cnt_reg;
  assign first_err_vec_o = first_err_reg;
  assign tt_seen_o       = tt_seen_reg;
  assign tt_done_o       = tt_done_reg;
  assign cov_map_o       = cov_map_reg;
  assign cov_done_o      = cov_done_reg;

endmodule

// File: tb/tb_fa_vector_checker.sv
// Scoreboard bench for fa_vector_checker: the driver pushes expected output
// values tagged with the cycle they apply to; a monitor pops and compares
// them on the falling edge. A second instance with CNT_W=2 covers saturation.
module tb_fa_vector_checker;
  import fa_chk_pkg::*;

  logic clk = 1'b0;
  logic rst, valid_i, a, b, c, y0, y1, flush_i, clear_i;

  logic        err;
  logic [15:0] err_cnt, vec_cnt;
  logic [4:0]  first_err;
  logic [7:0]  tt_seen;
  logic        tt_done;
  logic [63:0] cov_map;
  logic        cov_done;

  logic        s_err;
  logic [1:0]  s_err_cnt, s_vec_cnt;
  logic [4:0]  s_first_err;
  logic [7:0]  s_tt_seen;
  logic        s_tt_done;
  logic [63:0] s_cov_map;
  logic        s_cov_done;

  fa_vector_checker #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .a(a), .b(b), .c(c),
    .y0(y0), .y1(y1), .flush_i(flush_i), .clear_i(clear_i),
    .err_o(err), .err_cnt_o(err_cnt), .vec_cnt_o(vec_cnt),
    .first_err_vec_o(first_err), .tt_seen_o(tt_seen), .tt_done_o(tt_done),
    .cov_map_o(cov_map), .cov_done_o(cov_done)
  );

  fa_vector_checker #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .valid_i(valid_i), .a(a), .b(b), .c(c),
    .y0(y0), .y1(y1), .flush_i(flush_i), .clear_i(clear_i),
    .err_o(s_err), .err_cnt_o(s_err_cnt), .vec_cnt_o(s_vec_cnt),
    .first_err_vec_o(s_first_err), .tt_seen_o(s_tt_seen), .tt_done_o(s_tt_done),
    .cov_map_o(s_cov_map), .cov_done_o(s_cov_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int F_ERR = 0, F_ECNT = 1, F_VCNT = 2, F_FIRST = 3, F_TT = 4,
                 F_TTD = 5, F_COV = 6, F_COVD = 7, F_POP = 8, F_STATE = 9;

  typedef struct {
    int          cyc;
    int          sel;
    int          fld;
    logic [63:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Hand-computed full-adder truth table, bit v = response for vector v.
  logic [7:0] sum_t   = 8'b1001_0110;
  logic [7:0] carry_t = 8'b1110_1000;

  function automatic logic [1:0] ok_resp(input logic [2:0] v);
    return {carry_t[v], sum_t[v]};
  endfunction

  function automatic logic [63:0] get_act(input int sel, input int fld);
    logic [63:0] r;
    r = '0;
    if (sel == 0) begin
      case (fld)
        F_ERR:   r = 64'(err);
        F_ECNT:  r = 64'(err_cnt);
        F_VCNT:  r = 64'(vec_cnt);
        F_FIRST: r = 64'(first_err);
        F_TT:    r = 64'(tt_seen);
        F_TTD:   r = 64'(tt_done);
        F_COV:   r = cov_map;
        F_COVD:  r = 64'(cov_done);
        F_POP:   r = 64'($countones(cov_map & OFFDIAG_MASK));
        F_STATE: r = 64'(dut.state_reg);
        default: r = '1;
      endcase
    end else begin
      case (fld)
        F_ERR:   r = 64'(s_err);
        F_ECNT:  r = 64'(s_err_cnt);
        F_VCNT:  r = 64'(s_vec_cnt);
        F_FIRST: r = 64'(s_first_err);
        F_TT:    r = 64'(s_tt_seen);
        F_TTD:   r = 64'(s_tt_done);
        F_COV:   r = s_cov_map;
        F_COVD:  r = 64'(s_cov_done);
        F_POP:   r = 64'($countones(s_cov_map & OFFDIAG_MASK));
        F_STATE: r = 64'(dut_s.state_reg);
        default: r = '1;
      endcase
    end
    return r;
  endfunction

  // Monitor: compare every expectation due at this cycle.
  initial begin
    exp_t e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        checks++;
        act = get_act(e.sel, e.fld);
        if (e.cyc != cyc) begin
          failures++;
          $display("FAIL %s: stale expectation for cycle %0d at cycle %0d", e.name, e.cyc, cyc);
        end else if (act !== e.val) begin
          failures++;
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
        end else begin
          $display("check %s ok: %0h (cycle %0d)", e.name, act, cyc);
        end
      end
    end
  end

  task automatic expect_v(input int sel, input int fld, input logic [63:0] v, input string n);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.fld  = fld;
    e.val  = v;
    e.name = n;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [2:0] vec, input logic [1:0] resp,
                       input logic fl, input logic cl);
    valid_i = v;
    {a, b, c} = vec;
    {y1, y0} = resp;
    flush_i = fl;
    clear_i = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ok(input logic [2:0] vec);
    drive(1'b1, vec, ok_resp(vec), 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_zero(input int sel, input string tag);
    expect_v(sel, F_ERR,   0, {tag, "_err"});
    expect_v(sel, F_ECNT,  0, {tag, "_err_cnt"});
    expect_v(sel, F_VCNT,  0, {tag, "_vec_cnt"});
    expect_v(sel, F_FIRST, 0, {tag, "_first_err"});
    expect_v(sel, F_TT,    0, {tag, "_tt_seen"});
    expect_v(sel, F_TTD,   0, {tag, "_tt_done"});
    expect_v(sel, F_COV,   0, {tag, "_cov_map"});
    expect_v(sel, F_COVD,  0, {tag, "_cov_done"});
    expect_v(sel, F_STATE, 64'(IDLE), {tag, "_state"});
  endtask

  logic [2:0]  seq[65];
  logic [63:0] used;
  int          seq_len;
  int          offdiag_cnt;
  logic [5:0]  pidx;

  initial begin
    rst = 1'b1; valid_i = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;
    y0 = 1'b0; y1 = 1'b0; flush_i = 1'b0; clear_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset then idle cycles: everything stays zero.
    repeat (3) idle();
    expect_zero(0, "reset");
    expect_zero(1, "reset_s");

    // All eight vectors with correct responses.
    for (int v = 0; v < 8; v++) begin
      drive_ok(3'(v));
      if (v == 6) begin
        expect_v(0, F_TTD, 0, "tt_done_before_last");
        expect_v(0, F_COVD, 0, "cov_done_partial");
      end
    end
    expect_v(0, F_VCNT, 8, "walk_vec_cnt");
    expect_v(0, F_ECNT, 0, "walk_err_cnt");
    expect_v(0, F_ERR, 0, "walk_err");
    expect_v(0, F_TT, 64'hFF, "walk_tt_seen");
    expect_v(0, F_TTD, 1, "walk_tt_done");
    expect_v(0, F_COV, 64'h0080_4020_1008_0402, "walk_cov_map");

    // Two mismatches: only the first is captured.
    drive(1'b1, 3'b011, 2'b00, 1'b0, 1'b0);
    expect_v(0, F_ERR, 1, "mis1_err");
    expect_v(0, F_FIRST, 64'b01100, "mis1_first");
    expect_v(0, F_ECNT, 1, "mis1_err_cnt");
    drive(1'b1, 3'b110, 2'b01, 1'b0, 1'b0);
    expect_v(0, F_ECNT, 2, "mis2_err_cnt");
    expect_v(0, F_FIRST, 64'b01100, "mis2_first_held");
    expect_v(0, F_VCNT, 10, "mis2_vec_cnt");

    // Clear without a vector.
    drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    expect_zero(0, "clear");

    // All-transfers sequence (prefer-largest de Bruijn, alphabet 8, order 2).
    used = '0;
    seq[0] = 3'd0; seq[1] = 3'd0; used[0] = 1'b1; seq_len = 2;
    for (int k = 2; k < 65; k++) begin
      for (int d = 7; d >= 0; d--) begin
        pidx = {seq[k-1], 3'(d)};
        if (seq_len == k && !used[pidx]) begin
          used[pidx] = 1'b1;
          seq[k] = 3'(d);
          seq_len = k + 1;
        end
      end
    end
    used = '0;
    offdiag_cnt = 0;
    drive_ok(seq[0]);
    for (int k = 1; k < seq_len; k++) begin
      drive_ok(seq[k]);
      pidx = {seq[k-1], seq[k]};
      if (seq[k-1] != seq[k] && !used[pidx]) offdiag_cnt++;
      used[pidx] = 1'b1;
      expect_v(0, F_COVD, 64'(offdiag_cnt == 56), $sformatf("dbj_cov_done_%0d", k));
    end
    expect_v(0, F_POP, 56, "dbj_offdiag_popcount");
    expect_v(0, F_COV, '1, "dbj_cov_map_full");
    expect_v(0, F_VCNT, 65, "dbj_vec_cnt");
    expect_v(0, F_ERR, 0, "dbj_err");

    // Flush breaks the chain.
    drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    drive_ok(3'd0);
    drive(1'b0, 3'd0, 2'd0, 1'b1, 1'b0);
    drive_ok(3'd1);
    expect_v(0, F_COV, 0, "flush_cov_map");
    expect_v(0, F_STATE, 64'(RUN), "flush_then_run");
    // Idle cycles keep the chain.
    drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    drive_ok(3'd0);
    idle();
    idle();
    drive_ok(3'd1);
    expect_v(0, F_COV, 64'h2, "idle_cov_map");
    // Flush together with a vector: counted, not chained.
    drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    drive_ok(3'd0);
    drive(1'b1, 3'd1, ok_resp(3'd1), 1'b1, 1'b0);
    expect_v(0, F_VCNT, 2, "flushv_vec_cnt");
    expect_v(0, F_TT, 64'h03, "flushv_tt_seen");
    expect_v(0, F_COV, 0, "flushv_cov_map");
    expect_v(0, F_STATE, 64'(IDLE), "flushv_state");
    drive_ok(3'd2);
    expect_v(0, F_COV, 0, "after_flushv_cov_map");
    expect_v(0, F_VCNT, 3, "after_flushv_vec_cnt");

    // Saturation on the 2-bit instance.
    drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 3'd0, 2'b11, 1'b0, 1'b0);
      expect_v(1, F_ECNT, 64'(k > 3 ? 3 : k), $sformatf("sat_err_cnt_%0d", k));
      expect_v(1, F_VCNT, 64'(k > 3 ? 3 : k), $sformatf("sat_vec_cnt_%0d", k));
    end
    expect_v(1, F_ERR, 1, "sat_err");
    expect_v(1, F_FIRST, 64'b00011, "sat_first");
    // Clear wins over a presented vector.
    drive(1'b1, 3'd7, 2'b00, 1'b0, 1'b1);
    expect_zero(1, "clearv_s");
    expect_v(0, F_VCNT, 0, "clearv_vec_cnt");
    idle();
    expect_v(1, F_VCNT, 0, "clearv_s_after");
    expect_v(1, F_TT, 0, "clearv_s_tt_after");

    idle();
    idle();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
